// File: rtl/counter_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl_pkg
// Shared definitions for the JK-counter sequencing controller.
//   STATE_W : width of the controller state encoding
//   state_t : controller states (IDLE=0, RUN=1, HOLD=2, CLEAR=3); the
//             encoding is visible on the top-level state_o port.
// -----------------------------------------------------------------------------
package counter_seq_ctrl_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_HOLD  = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

endpackage

// File: rtl/counter_presc.sv
// -----------------------------------------------------------------------------
// counter_presc
// Modulo-DIV prescaler that paces the counter when the prescaler build option
// (CTRL_PRESCALE_EN) is selected in counter_seq_ctrl.
// Ports:
//   clk     in  system clock, rising edge
//   rst_n   in  asynchronous active-low reset (count -> 0)
//   i_en    in  advance the count by one (wrapping at DIV-1)
//   i_clr   in  synchronous clear to 0, dominates i_en
//   o_tick  out high while the count sits at DIV-1
// -----------------------------------------------------------------------------
module counter_presc #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/counter_seq_ctrl.sv
// -----------------------------------------------------------------------------
// counter_seq_ctrl
// Sequencing controller for a reset-less JK-flip-flop ripple/sync counter.
// It drives the counter's count enable and watches its q outputs to provide
// start / stop / clear, a programmable terminal count and one-shot or
// periodic operation. The counter itself cannot be reset, so "clear" works by
// letting the counter run forward through its wrap until it reads zero.
//
// Build option: define CTRL_PRESCALE_EN to pace counting with a modulo
// PRESC_DIV prescaler (counter_presc). Without it every cycle is a tick.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin (from IDLE) or resume (from HOLD) counting
//   stop      in   pause counting (RUN -> HOLD)
//   clr       in   drive counter back to 0, then go idle
//   periodic  in   sampled at start: 1 = auto-restart after terminal count
//   limit     in   terminal count, sampled at start
//   q_in      in   counter q outputs
//   cnt_en    out  counter enable (combinational)
//   busy      out  controller not idle
//   done      out  registered one-cycle pulse after the terminal-count edge
//   state_o   out  current state encoding
// -----------------------------------------------------------------------------
module counter_seq_ctrl
    import counter_seq_ctrl_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int PRESC_DIV = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               clr,
    input  logic               periodic,
    input  logic [WIDTH-1:0]   limit,
    input  logic [WIDTH-1:0]   q_in,
    output logic               cnt_en,
    output logic               busy,
    output logic               done,
    output logic [STATE_W-1:0] state_o
);

    // Catch an illegal prescale ratio at elaboration time.
    if (PRESC_DIV < 2 || PRESC_DIV > 255) begin : g_bad_presc_div
        $error("counter_seq_ctrl: PRESC_DIV must be in 2..255");
    end

    state_t           r_state;
    logic [WIDTH-1:0] r_limit_q;
    logic             r_per_q;
    logic             r_ret_run;
    logic             r_done;

    state_t           w_state_next;
    logic [WIDTH-1:0] w_limit_next;
    logic             w_per_next;
    logic             w_ret_next;
    logic             w_done_next;
    logic             w_match;
    logic             w_zero;
    logic             w_tick;

`ifdef CTRL_PRESCALE_EN
    // Prescaler runs only while the counter is meant to move, freezes in
    // HOLD so a resume continues the same slot, and restarts from 0 in IDLE.
    counter_presc #(
        .DIV    (PRESC_DIV)
    ) u_presc (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   ((r_state == S_RUN) || (r_state == S_CLEAR)),
        .i_clr  (r_state == S_IDLE),
        .o_tick (w_tick)
    );
`else
    assign w_tick = 1'b1;
`endif

    assign w_match = (q_in == r_limit_q);
    assign w_zero  = (q_in == '0);

    always_comb begin
        w_state_next = r_state;
        w_limit_next = r_limit_q;
        w_per_next   = r_per_q;
        w_ret_next   = r_ret_run;
        w_done_next  = 1'b0;
        cnt_en       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (clr) begin
                    w_state_next = S_CLEAR;
                    w_ret_next   = 1'b0;
                end else if (start) begin
                    w_state_next = S_RUN;
                    w_limit_next = limit;
                    w_per_next   = periodic;
                end
            end

            S_RUN: begin
                cnt_en = !w_match && w_tick;
                if (clr) begin
                    // Clear wins over a coincident match: no done pulse.
                    w_state_next = S_CLEAR;
                    w_ret_next   = 1'b0;
                end else if (w_match && w_tick) begin
                    // Match wins over stop; periodic mode wraps back to 0
                    // and then resumes counting on its own.
                    w_done_next  = 1'b1;
                    w_state_next = r_per_q ? S_CLEAR : S_IDLE;
                    w_ret_next   = r_per_q;
                end else if (stop) begin
                    w_state_next = S_HOLD;
                end
            end

            S_HOLD: begin
                if (clr) begin
                    w_state_next = S_CLEAR;
                    w_ret_next   = 1'b0;
                end else if (start && !stop) begin
                    w_state_next = S_RUN;
                end
            end

            S_CLEAR: begin
                cnt_en = !w_zero && w_tick;
                if (clr) begin
                    w_ret_next = 1'b0;
                end
                if (w_zero && w_tick) begin
                    w_state_next = (r_ret_run && !clr) ? S_RUN : S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_limit_q <= '0;
            r_per_q   <= 1'b0;
            r_ret_run <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_limit_q <= w_limit_next;
            r_per_q   <= w_per_next;
            r_ret_run <= w_ret_next;
            r_done    <= w_done_next;
        end
    end

    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign state_o = r_state;

endmodule
